// File: rtl/fetch_ifid_stage.sv
// Fetch front end: PC register plus IF/ID pipeline register, steered by the hazard unit.
// Also keeps saturating stall/flush event counters and a sticky flag for the reserved control code.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pc_hold_i,
    input  logic [1:0]       ifid_ctrl_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_target_i,
    input  logic [31:0]      imem_instr_i,
    input  logic             cnt_clr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             ctrl_err_o
);

    typedef enum logic [1:0] {
        IFID_LOAD     = 2'b00,
        IFID_STALL    = 2'b01,
        IFID_RESERVED = 2'b10,
        IFID_FLUSH    = 2'b11
    } ifid_ctrl_t;

    ifid_ctrl_t  ctrl;
    logic [31:0] pc_plus4;

    assign ctrl     = ifid_ctrl_t'(ifid_ctrl_i);
    assign pc_plus4 = pc_o + 32'd4;

    // PC register: a taken redirect from EX wins over the hazard hold.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_o <= RESET_PC;
        end else if (br_taken_i) begin
            pc_o <= br_target_i;
        end else if (!pc_hold_i) begin
            pc_o <= pc_plus4;
        end
    end

    // IF/ID register; the reserved code behaves like a load so the pipe keeps moving.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ifid_pc_o    <= RESET_PC;
            ifid_instr_o <= NOP_INSTR;
            ifid_valid_o <= 1'b0;
        end else begin
            case (ctrl)
                IFID_STALL: begin
                    ifid_pc_o    <= ifid_pc_o;
                    ifid_instr_o <= ifid_instr_o;
                    ifid_valid_o <= ifid_valid_o;
                end
                IFID_FLUSH: begin
                    ifid_pc_o    <= pc_o;
                    ifid_instr_o <= NOP_INSTR;
                    ifid_valid_o <= 1'b0;
                end
                default: begin
                    ifid_pc_o    <= pc_o;
                    ifid_instr_o <= imem_instr_i;
                    ifid_valid_o <= 1'b1;
                end
            endcase
        end
    end

    assign ifid_pc4_o = ifid_pc_o + 32'd4;

    // Debug counters saturate at all-ones; a clear beats an increment in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            ctrl_err_o  <= 1'b0;
        end else begin
            if (cnt_clr_i) begin
                stall_cnt_o <= '0;
                flush_cnt_o <= '0;
            end else begin
                if (ctrl == IFID_STALL && stall_cnt_o != {CNT_W{1'b1}}) begin
                    stall_cnt_o <= stall_cnt_o + 1'b1;
                end
                if (ctrl == IFID_FLUSH && flush_cnt_o != {CNT_W{1'b1}}) begin
                    flush_cnt_o <= flush_cnt_o + 1'b1;
                end
            end
            if (ctrl == IFID_RESERVED) begin
                ctrl_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed testbench for fetch_ifid_stage; imem is modelled as a small lookup table.
// Counters are built 4 bits wide so saturation is reachable in a few cycles.
module tb_fetch_ifid_stage;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             pc_hold_i;
    logic [1:0]       ifid_ctrl_i;
    logic             br_taken_i;
    logic [31:0]      br_target_i;
    logic [31:0]      imem_instr_i;
    logic             cnt_clr_i;
    logic [31:0]      pc_o;
    logic [31:0]      ifid_pc_o;
    logic [31:0]      ifid_pc4_o;
    logic [31:0]      ifid_instr_o;
    logic             ifid_valid_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             ctrl_err_o;

    int errors = 0;
    int checks = 0;

    fetch_ifid_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .pc_hold_i   (pc_hold_i),
        .ifid_ctrl_i (ifid_ctrl_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .imem_instr_i(imem_instr_i),
        .cnt_clr_i   (cnt_clr_i),
        .pc_o        (pc_o),
        .ifid_pc_o   (ifid_pc_o),
        .ifid_pc4_o  (ifid_pc4_o),
        .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o),
        .ctrl_err_o  (ctrl_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: three real instructions at 0/4/8, a PC-tagged pattern elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0: return 32'h00A0_0093;
            32'h4: return 32'h0010_0113;
            32'h8: return 32'h0020_81B3;
            default: return addr ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_comb imem_instr_i = imem(pc_o);

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; pc_hold_i = 1'b1; ifid_ctrl_i = 2'b11;
        br_taken_i = 1'b1; br_target_i = 32'h1234_5678; cnt_clr_i = 1'b0;
        step();
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
        checks++; if (ifid_pc_o !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got=%h exp=%h", ifid_pc_o, 32'h0); end
        checks++; if (ifid_pc4_o !== 32'h4) begin errors++; $display("FAIL reset_ifid_pc4 got=%h exp=%h", ifid_pc4_o, 32'h4); end
        checks++; if (ifid_instr_o !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr_o, 32'h13); end
        checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid_o); end
        checks++; if (stall_cnt_o !== 4'h0 || flush_cnt_o !== 4'h0) begin errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt_o, flush_cnt_o); end
        checks++; if (ctrl_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ctrl_err_o); end
        rst_ni = 1'b1; pc_hold_i = 1'b0; ifid_ctrl_i = 2'b00; br_taken_i = 1'b0; br_target_i = 32'h0;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h00A0_0093;
        exp_instr[1] = 32'h0010_0113;
        exp_instr[2] = 32'h0020_81B3;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_o !== 32'(4 * (i + 1))) begin errors++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, pc_o, 32'(4 * (i + 1))); end
            checks++; if (ifid_pc_o !== 32'(4 * i) || ifid_pc4_o !== 32'(4 * i + 4)) begin errors++; $display("FAIL run_ifid_pc[%0d] got=%h/%h exp=%h/%h", i, ifid_pc_o, ifid_pc4_o, 32'(4 * i), 32'(4 * i + 4)); end
            checks++; if (ifid_instr_o !== exp_instr[i] || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL run_instr[%0d] got=%h/%b exp=%h/1", i, ifid_instr_o, ifid_valid_o, exp_instr[i]); end
        end
        step();
        checks++; if (pc_o !== 32'h10 || ifid_instr_o !== 32'h5A5A_000C) begin errors++; $display("FAIL run_pc10 got=%h/%h exp=%h/%h", pc_o, ifid_instr_o, 32'h10, 32'h5A5A_000C); end
    endtask

    task automatic test_stall();
        pc_hold_i = 1'b1; ifid_ctrl_i = 2'b01;
        step();
        step();
        checks++; if (pc_o !== 32'h10) begin errors++; $display("FAIL stall_pc got=%h exp=%h", pc_o, 32'h10); end
        checks++; if (ifid_pc_o !== 32'hC || ifid_instr_o !== 32'h5A5A_000C || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold got=%h/%h/%b exp=%h/%h/1", ifid_pc_o, ifid_instr_o, ifid_valid_o, 32'hC, 32'h5A5A_000C); end
        checks++; if (stall_cnt_o !== 4'd2) begin errors++; $display("FAIL stall_cnt got=%0d exp=2", stall_cnt_o); end
        pc_hold_i = 1'b0; ifid_ctrl_i = 2'b00;
        step();
        checks++; if (pc_o !== 32'h14 || ifid_pc_o !== 32'h10 || ifid_instr_o !== 32'h5A5A_0010) begin errors++; $display("FAIL stall_resume got=%h/%h/%h exp=%h/%h/%h", pc_o, ifid_pc_o, ifid_instr_o, 32'h14, 32'h10, 32'h5A5A_0010); end
    endtask

    task automatic test_branch();
        step(); step(); step();
        checks++; if (pc_o !== 32'h20) begin errors++; $display("FAIL br_setup_pc got=%h exp=%h", pc_o, 32'h20); end
        br_taken_i = 1'b1; br_target_i = 32'h100; ifid_ctrl_i = 2'b11;
        step();
        checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL br_pc got=%h exp=%h", pc_o, 32'h100); end
        checks++; if (ifid_instr_o !== 32'h13 || ifid_valid_o !== 1'b0 || ifid_pc_o !== 32'h20) begin errors++; $display("FAIL br_flush got=%h/%b/%h exp=%h/0/%h", ifid_instr_o, ifid_valid_o, ifid_pc_o, 32'h13, 32'h20); end
        checks++; if (flush_cnt_o !== 4'd1) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt_o); end
        br_taken_i = 1'b0; ifid_ctrl_i = 2'b00;
        step();
        checks++; if (pc_o !== 32'h104 || ifid_pc_o !== 32'h100 || ifid_instr_o !== 32'h5A5A_0100 || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL br_target_load got=%h/%h/%h/%b exp=%h/%h/%h/1", pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, 32'h104, 32'h100, 32'h5A5A_0100); end
    endtask

    task automatic test_redirect_hold();
        br_taken_i = 1'b1; pc_hold_i = 1'b1; br_target_i = 32'h40; ifid_ctrl_i = 2'b01;
        step();
        checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL redir_hold_pc got=%h exp=%h", pc_o, 32'h40); end
        checks++; if (ifid_pc_o !== 32'h100 || stall_cnt_o !== 4'd3) begin errors++; $display("FAIL redir_hold_ifid got=%h/%0d exp=%h/3", ifid_pc_o, stall_cnt_o, 32'h100); end
        br_taken_i = 1'b0; ifid_ctrl_i = 2'b00;
        step();
        step();
        checks++; if (pc_o !== 32'h40 || ifid_pc_o !== 32'h40 || ifid_instr_o !== 32'h5A5A_0040 || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL hold_load got=%h/%h/%h/%b exp=%h/%h/%h/1", pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, 32'h40, 32'h40, 32'h5A5A_0040); end
        checks++; if (stall_cnt_o !== 4'd3 || ctrl_err_o !== 1'b0) begin errors++; $display("FAIL hold_only_cnt got=%0d/%b exp=3/0", stall_cnt_o, ctrl_err_o); end
        pc_hold_i = 1'b0;
    endtask

    task automatic test_wrap();
        br_taken_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
        step();
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got=%h exp=%h", pc_o, 32'hFFFF_FFFC); end
        br_taken_i = 1'b0;
        step();
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc_o, 32'h0); end
        checks++; if (ifid_pc_o !== 32'hFFFF_FFFC || ifid_pc4_o !== 32'h0 || ifid_instr_o !== 32'hA5A5_FFFC) begin errors++; $display("FAIL wrap_ifid got=%h/%h/%h exp=%h/%h/%h", ifid_pc_o, ifid_pc4_o, ifid_instr_o, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_FFFC); end
        br_taken_i = 1'b1; br_target_i = 32'h102;
        step();
        checks++; if (pc_o !== 32'h102) begin errors++; $display("FAIL misaligned_pc got=%h exp=%h", pc_o, 32'h102); end
        br_taken_i = 1'b0;
    endtask

    task automatic test_saturation();
        cnt_clr_i = 1'b1; ifid_ctrl_i = 2'b11;
        step();
        checks++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin errors++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
        cnt_clr_i = 1'b0; pc_hold_i = 1'b1; ifid_ctrl_i = 2'b01;
        for (int i = 0; i < 20; i++) step();
        checks++; if (stall_cnt_o !== 4'hF) begin errors++; $display("FAIL stall_sat got=%h exp=%h", stall_cnt_o, 4'hF); end
        ifid_ctrl_i = 2'b11;
        for (int i = 0; i < 17; i++) step();
        checks++; if (flush_cnt_o !== 4'hF || stall_cnt_o !== 4'hF) begin errors++; $display("FAIL flush_sat got=%h/%h exp=%h/%h", flush_cnt_o, stall_cnt_o, 4'hF, 4'hF); end
        cnt_clr_i = 1'b1; ifid_ctrl_i = 2'b01;
        step();
        checks++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin errors++; $display("FAIL clr_beats_inc got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
        cnt_clr_i = 1'b0; pc_hold_i = 1'b0; ifid_ctrl_i = 2'b00;
    endtask

    task automatic test_reserved_reset();
        br_taken_i = 1'b1; br_target_i = 32'h200;
        step();
        br_taken_i = 1'b0; ifid_ctrl_i = 2'b10;
        step();
        checks++; if (ctrl_err_o !== 1'b1) begin errors++; $display("FAIL resv_err got=%b exp=1", ctrl_err_o); end
        checks++; if (pc_o !== 32'h204 || ifid_pc_o !== 32'h200 || ifid_instr_o !== 32'h5A5A_0200 || ifid_valid_o !== 1'b1) begin errors++; $display("FAIL resv_load got=%h/%h/%h/%b exp=%h/%h/%h/1", pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, 32'h204, 32'h200, 32'h5A5A_0200); end
        pc_hold_i = 1'b1; ifid_ctrl_i = 2'b01;
        step();
        checks++; if (ctrl_err_o !== 1'b1 || stall_cnt_o !== 4'd1) begin errors++; $display("FAIL resv_sticky got=%b/%0d exp=1/1", ctrl_err_o, stall_cnt_o); end
        rst_ni = 1'b0;
        step();
        checks++; if (pc_o !== 32'h0 || ifid_pc_o !== 32'h0 || ifid_pc4_o !== 32'h4 || ifid_instr_o !== 32'h13 || ifid_valid_o !== 1'b0) begin errors++; $display("FAIL midstall_reset got=%h/%h/%h/%h/%b exp=0/0/4/13/0", pc_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o); end
        checks++; if (ctrl_err_o !== 1'b0 || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin errors++; $display("FAIL midstall_reset_cnt got=%b/%0d/%0d exp=0/0/0", ctrl_err_o, stall_cnt_o, flush_cnt_o); end
        rst_ni = 1'b1; pc_hold_i = 1'b0; ifid_ctrl_i = 2'b00;
        step();
        checks++; if (pc_o !== 32'h4 || ifid_instr_o !== 32'h00A0_0093 || ctrl_err_o !== 1'b0) begin errors++; $display("FAIL post_reset got=%h/%h/%b exp=%h/%h/0", pc_o, ifid_instr_o, ctrl_err_o, 32'h4, 32'h00A0_0093); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_redirect_hold();
        test_wrap();
        test_saturation();
        test_reserved_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
